// File: rtl/cfu_pkg.sv
// Purpose : shared opcode constants and FSM state type for the SIMD MAC CFU.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package cfu_pkg;

    // funct3 operation selects
    localparam logic [2:0] CFU_OR    = 3'd0;
    localparam logic [2:0] CFU_ADDV  = 3'd1;
    localparam logic [2:0] CFU_DOT   = 3'd2;
    localparam logic [2:0] CFU_RDACC = 3'd3;
    localparam logic [2:0] CFU_WRACC = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cfu_state_t;

endpackage

// File: rtl/cfu_lane_mul.sv
// Purpose : one SIMD lane multiplier, signed or unsigned, full 2*LANE_W product.
// Latency : purely combinational.
// Backpr. : none.
// Ports   : a, b - lane operands; uns - 1 treats both as unsigned; prod - product.
module cfu_lane_mul #(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0]   a,
    input  logic [LANE_W-1:0]   b,
    input  logic                uns,
    output logic [2*LANE_W-1:0] prod
);

    // One extra bit lets a single signed multiplier serve both modes:
    // unsigned lanes get a 0 top bit, signed lanes replicate their MSB.
    logic signed [LANE_W:0] a_x;
    logic signed [LANE_W:0] b_x;

    assign a_x = {~uns & a[LANE_W-1], a};
    assign b_x = {~uns & b[LANE_W-1], b};

    // Both products fit in 2*LANE_W bits, so the low half is exact.
    assign prod = (2*LANE_W)'(a_x) * (2*LANE_W)'(b_x);

endmodule

// File: rtl/cfu_simd_mac.sv
// Purpose : CFU with OR, lane-wise ADDV, multi-cycle packed DOT into an accumulator, acc read/write.
// Latency : OR/ADDV/RDACC/WRACC/reserved same cycle; DOT result after LANES+1 stall cycles.
// Backpr. : stall_o holds the pipeline from DOT issue through the last BUSY cycle.
// Ports   : clk_i, rst_ni (async active-low); en_i instruction valid; funct3_i op select;
//           funct7_i[0] unsigned DOT; src1_i/src2_i operands; stall_o hold; rslt_o result.
module cfu_simd_mac
    import cfu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LANE_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rslt_o
);

    localparam int LANES = XLEN / LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

    cfu_state_t                     state;
    logic [CNT_W-1:0]               cnt;
    logic [ACC_W-1:0]               acc;
    logic [LANES-1:0][LANE_W-1:0]   a_q;
    logic [LANES-1:0][LANE_W-1:0]   b_q;
    logic                           uns_q;

    logic [2*LANE_W-1:0]            prod;
    logic [ACC_W-1:0]               prod_ext;
    logic [XLEN-1:0]                acc_sx;
    logic [LANES-1:0][LANE_W-1:0]   s1;
    logic [LANES-1:0][LANE_W-1:0]   s2;
    logic [LANES-1:0][LANE_W-1:0]   addv;

    // Only funct7[0] carries meaning.
    logic unused_funct7;
    assign unused_funct7 = ^funct7_i[6:1];

    // Single shared multiplier; the latched operands are walked one lane per BUSY cycle.
    cfu_lane_mul #(
        .LANE_W (LANE_W)
    ) u_lane_mul (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .uns  (uns_q),
        .prod (prod)
    );

    // Unsigned products can have their top bit set, so extension follows the mode.
    assign prod_ext = uns_q ? ACC_W'(prod) : ACC_W'($signed(prod));
    assign acc_sx   = XLEN'($signed(acc));

    assign s1 = src1_i;
    assign s2 = src2_i;

    always_comb begin
        addv = '0;
        for (int i = 0; i < LANES; i++) begin
            addv[i] = s1[i] + s2[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            uns_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) begin
                        if (funct3_i == CFU_DOT) begin
                            a_q   <= src1_i;
                            b_q   <= src2_i;
                            uns_q <= funct7_i[0];
                            cnt   <= '0;
                            state <= BUSY;
                        end else if (funct3_i == CFU_WRACC) begin
                            acc <= src1_i[ACC_W-1:0];
                        end
                    end
                end
                BUSY: begin
                    acc <= acc + prod_ext;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                // en_i seen here belongs to the instruction that is completing.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Results in IDLE are combinational so single-cycle ops keep zero latency.
    // stall_o never looks at the source operands.
    always_comb begin
        stall_o = 1'b0;
        rslt_o  = '0;
        case (state)
            IDLE: begin
                if (en_i) begin
                    case (funct3_i)
                        CFU_OR:    rslt_o  = src1_i | src2_i;
                        CFU_ADDV:  rslt_o  = addv;
                        CFU_DOT:   stall_o = 1'b1;
                        CFU_RDACC: rslt_o  = acc_sx;
                        CFU_WRACC: rslt_o  = acc_sx;
                        default:   rslt_o  = '0;
                    endcase
                end
            end
            BUSY:    stall_o = 1'b1;
            DONE:    rslt_o  = acc_sx;
            default: ;
        endcase
        // Outputs must drop the moment reset asserts, even with en_i still high.
        if (!rst_ni) begin
            stall_o = 1'b0;
            rslt_o  = '0;
        end
    end

endmodule

// File: tb/tb_cfu_simd_mac.sv
module tb_cfu_simd_mac;

    localparam int XLEN   = 32;
    localparam int LANE_W = 8;
    localparam int LANES  = XLEN / LANE_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic              stall;
    logic [XLEN-1:0]   rslt;

    int vectors     = 0;
    int miscompares = 0;

    // Expected outputs for the current cycle, set by the stimulus, checked at negedge.
    logic              chk_en = 1'b0;
    logic              exp_stall = 1'b0;
    logic [XLEN-1:0]   exp_rslt = '0;
    logic [31:0]       model_acc = '0;

    always #5 clk = ~clk;

    cfu_simd_mac #(
        .XLEN   (XLEN),
        .LANE_W (LANE_W),
        .ACC_W  (32)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .src1_i   (src1),
        .src2_i   (src2),
        .stall_o  (stall),
        .rslt_o   (rslt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic over lanes.
    function automatic logic [31:0] dot_model(input logic [31:0] acc, input logic [31:0] a,
                                              input logic [31:0] b, input logic uns);
        longint s;
        logic [7:0] la, lb;
        byte sa, sb;
        int ai, bi;
        s = longint'(acc);
        for (int i = 0; i < LANES; i++) begin
            la = a[i*8 +: 8];
            lb = b[i*8 +: 8];
            sa = la;
            sb = lb;
            ai = uns ? int'(la) : int'(sa);
            bi = uns ? int'(lb) : int'(sb);
            s  = s + longint'(ai * bi);
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] addv_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int la, lb;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            la = int'(a[i*8 +: 8]);
            lb = int'(b[i*8 +: 8]);
            r[i*8 +: 8] = 8'((la + lb) % 256);
        end
        return r;
    endfunction

    // The single compare process.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("rslt", rslt, exp_rslt);
        end
    end

    // Called just after a posedge; leaves the bench just after a posedge in IDLE.
    task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res);
        en = 1'b1; funct3 = f3; funct7 = f7; src1 = a; src2 = b;
        if (f3 == 3'd2) begin
            exp_stall = 1'b1; exp_rslt = '0;
            model_acc = dot_model(model_acc, a, b, f7[0]);
            @(posedge clk); #1;
            for (int i = 0; i < LANES; i++) begin
                // Scramble every input; the latched operands must carry the op.
                en = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
                funct7 = 7'($urandom); src1 = $urandom; src2 = $urandom;
                exp_stall = 1'b1; exp_rslt = '0;
                @(posedge clk); #1;
            end
            // Completing instruction still presents en with a DOT opcode.
            en = 1'b1; funct3 = 3'd2; src1 = $urandom; src2 = $urandom;
            exp_stall = 1'b0; exp_rslt = model_acc;
            @(negedge clk); res = rslt;
            @(posedge clk); #1;
        end else begin
            exp_stall = 1'b0;
            case (f3)
                3'd0:    exp_rslt = a | b;
                3'd1:    exp_rslt = addv_model(a, b);
                3'd3:    exp_rslt = model_acc;
                3'd4:    exp_rslt = model_acc;
                default: exp_rslt = '0;
            endcase
            @(negedge clk); res = rslt;
            @(posedge clk); #1;
            if (f3 == 3'd4) model_acc = a;
        end
        en = 1'b0; exp_stall = 1'b0; exp_rslt = '0;
    endtask

    task automatic idle_cycle();
        en = 1'b0; funct3 = 3'($urandom_range(0, 7)); src1 = $urandom; src2 = $urandom;
        exp_stall = 1'b0; exp_rslt = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; en = 1'b0; funct3 = '0; funct7 = '0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_rslt", rslt, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        issue(3'd3, 7'd0, 32'h1234_5678, 32'h0, r);
        check("rdacc_after_reset", r, 32'h0000_0000);

        issue(3'd0, 7'd0, 32'h0F0F_0000, 32'h0000_00F0, r);
        check("or", r, 32'h0F0F_00F0);
        idle_cycle();

        issue(3'd1, 7'd0, 32'h01FF_7F80, 32'h0101_0101, r);
        check("addv", r, 32'h0200_8081);

        issue(3'd2, 7'd0, 32'h0102_0304, 32'h0506_0708, r);
        check("dot1", r, 32'h0000_0046);
        issue(3'd2, 7'd0, 32'h0102_0304, 32'h0506_0708, r);
        check("dot2", r, 32'h0000_008C);

        issue(3'd4, 7'd0, 32'h0, 32'h0, r);
        check("wracc0_old", r, 32'h0000_008C);
        issue(3'd2, 7'd0, 32'hFFFF_FFFF, 32'h0101_0101, r);
        check("dot_signed", r, 32'hFFFF_FFFC);
        issue(3'd4, 7'd0, 32'h0, 32'h0, r);
        issue(3'd2, 7'd1, 32'hFFFF_FFFF, 32'h0101_0101, r);
        check("dot_unsigned", r, 32'h0000_03FC);

        issue(3'd4, 7'd0, 32'h7FFF_FFFF, 32'h0, r);
        check("wracc_old", r, 32'h0000_03FC);
        issue(3'd2, 7'd0, 32'h0000_0001, 32'h0000_0001, r);
        check("dot_wrap", r, 32'h8000_0000);
        issue(3'd3, 7'd0, 32'h0, 32'h0, r);
        check("rdacc_wrap", r, 32'h8000_0000);
        issue(3'd5, 7'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
        check("reserved", r, 32'h0000_0000);

        // Randomised mix, including back-to-back DOTs.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            issue(3'($urandom_range(0, 7)), 7'($urandom), $urandom, $urandom, r);
        end

        // Reset asserted in BUSY cycle T2 with en still high.
        issue(3'd4, 7'd0, 32'h5555_AAAA, 32'h0, r);
        en = 1'b1; funct3 = 3'd2; funct7 = '0; src1 = 32'h7F7F_7F7F; src2 = 32'h7F7F_7F7F;
        exp_stall = 1'b1; exp_rslt = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy_stall", {31'd0, stall}, 32'd0);
        check("rst_busy_rslt", rslt, 32'd0);
        model_acc = '0;
        en = 1'b0; exp_stall = 1'b0; exp_rslt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'd3, 7'd0, 32'h0, 32'h0, r);
        check("rdacc_after_rst", r, 32'h0000_0000);
        idle_cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
